// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - round-robin arbiter sharing one Avalon-MM pixel write master among shaders
// Optional stats counters (write_count, stall_count) built only when PIXEL_ARB_STATS_EN is defined.
module pixel_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [ADDR_W-1:0]           m1_address,
    output logic [DATA_W-1:0]           m1_writedata,
    output logic                        m1_write,
    input  logic                        m1_waitrequest,
    output logic                        idle,
    output logic                        align_error,
    output logic [31:0]                 write_count,
    output logic [31:0]                 stall_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  idx_sel;
    logic              found;
    int                idx;
    logic              any_valid;
    logic              can_accept;
    logic              handshake;
    logic              misaligned;
    logic              load;
    logic [ADDR_W-1:0] grant_address;
    logic [DATA_W-1:0] grant_data;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        grant   = last_grant;
        found   = 1'b0;
        idx     = 0;
        idx_sel = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx     = (int'(last_grant) + k) % NUM_REQ;
            idx_sel = IDX_W'(idx);
            if (!found && req_valid[idx_sel]) begin
                grant = idx_sel;
                found = 1'b1;
            end
        end
    end

    assign grant_address = req_address[int'(grant)*ADDR_W +: ADDR_W];
    assign grant_data    = req_writedata[int'(grant)*DATA_W +: DATA_W];
    assign misaligned    = grant_address[0];

    assign any_valid  = |req_valid;
    assign can_accept = (state == IDLE) | ~m1_waitrequest;
    assign handshake  = can_accept & any_valid;
    assign load       = handshake & ~misaligned;

    // Misaligned requests still get their ready pulse so the shader is not stuck.
    always_comb begin
        req_ready = '0;
        if (handshake && !reset) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!m1_waitrequest) begin
                    state_next = load ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m1_address   <= '0;
            m1_writedata <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            align_error  <= 1'b0;
        end else begin
            if (load) begin
                m1_address   <= grant_address;
                m1_writedata <= grant_data;
            end
            if (handshake) begin
                last_grant <= grant;
            end
            if (handshake && misaligned) begin
                align_error <= 1'b1;
            end
        end
    end

    assign m1_write = (state == ISSUE);
    assign idle     = (state == IDLE) & ~any_valid;

`ifdef PIXEL_ARB_STATS_EN
    logic write_done;
    logic stall_cycle;

    assign write_done  = (state == ISSUE) & ~m1_waitrequest;
    assign stall_cycle = m1_write & m1_waitrequest;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_count <= '0;
            stall_count <= '0;
        end else begin
            if (write_done && write_count != 32'hFFFF_FFFF) begin
                write_count <= write_count + 32'd1;
            end
            if (stall_cycle && stall_count != 32'hFFFF_FFFF) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    assign write_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - vector table, corner sequences and randomized framebuffer fill for pixel_write_arbiter
module tb_pixel_write_arbiter;

    localparam int NPIX = 160 * 120;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] a [4];
    logic [15:0] d [4];
    logic [127:0] req_address;
    logic [63:0] req_writedata;
    logic [31:0] m1_address;
    logic [15:0] m1_writedata;
    logic        m1_write;
    logic        m1_waitrequest;
    logic        idle;
    logic        align_error;
    logic [31:0] write_count;
    logic [31:0] stall_count;

    assign req_address   = {a[3], a[2], a[1], a[0]};
    assign req_writedata = {d[3], d[2], d[1], d[0]};

    pixel_write_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_writedata(req_writedata),
        .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
        .idle(idle), .align_error(align_error),
        .write_count(write_count), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       wr;
        logic [3:0] exp_ready;
        logic       exp_write;
        int         sel;
    } vec_t;

    vec_t vt [12];

    logic [15:0] fb [32768];
    logic [47:0] exp_q [$];

    function automatic logic [15:0] pix_val(input int r, input int c);
        return 16'((r * 256 + c) ^ 16'h5A5A);
    endfunction

    task automatic do_reset();
        reset          = 1'b1;
        req_valid      = 4'b1111;
        m1_waitrequest = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_ready_forced0", req_ready, 4'b0000);
        check("reset_m1_write", m1_write, 1'b0);
        check("reset_m1_address", m1_address, 32'h0);
        check("reset_align_error", align_error, 1'b0);
        @(negedge clock);
        req_valid = 4'b0000;
        reset     = 1'b0;
    endtask

    logic [31:0] base_stall, base_write;

    initial begin
        a[0] = 32'h0800_0010; d[0] = 16'hA000;
        a[1] = 32'h0800_0020; d[1] = 16'hA001;
        a[2] = 32'h0800_0004; d[2] = 16'h1111;
        a[3] = 32'h0800_0030; d[3] = 16'hA003;

        //            valid    wr    ready    write sel
        vt[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
        vt[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 0};
        vt[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2};
        vt[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
        vt[4]  = '{4'b1111, 1'b0, 4'b1000, 1'b0, 0};
        vt[5]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3};
        vt[6]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 0};
        vt[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1};
        vt[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1};
        vt[9]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 1};
        vt[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2};
        vt[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            req_valid      = vt[i].valid;
            m1_waitrequest = vt[i].wr;
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, vt[i].exp_ready);
            check($sformatf("vec%0d_write", i), m1_write, vt[i].exp_write);
            check($sformatf("vec%0d_idle", i), idle, (!vt[i].exp_write && vt[i].valid == 4'b0000));
            if (vt[i].exp_write) begin
                check($sformatf("vec%0d_addr", i), m1_address, a[vt[i].sel]);
                check($sformatf("vec%0d_data", i), m1_writedata, d[vt[i].sel]);
            end
        end

        // Stall: shader 1 write held for 5 waitrequest cycles
        @(negedge clock);
        a[1] = 32'h0800_0040; d[1] = 16'h2222;
        req_valid      = 4'b0010;
        m1_waitrequest = 1'b1;
        #1;
        check("stall_accept_ready", req_ready, 4'b0010);
        base_stall = stall_count;
        base_write = write_count;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            req_valid      = (c < 5) ? 4'b0101 : 4'b0000;
            m1_waitrequest = (c < 5);
            #1;
            check($sformatf("stall%0d_write", c), m1_write, 1'b1);
            check($sformatf("stall%0d_addr", c), m1_address, 32'h0800_0040);
            check($sformatf("stall%0d_data", c), m1_writedata, 16'h2222);
            if (c < 5) check($sformatf("stall%0d_ready", c), req_ready, 4'b0000);
        end
        @(negedge clock);
        req_valid = 4'b0000;
        #1;
        check("stall_done_write", m1_write, 1'b0);
`ifdef PIXEL_ARB_STATS_EN
        check("stall_count_delta", stall_count - base_stall, 32'd5);
        check("write_count_delta", write_count - base_write, 32'd1);
`else
        check("stall_count_tied0", stall_count, 32'd0);
        check("write_count_tied0", write_count, 32'd0);
`endif

        // Misaligned request from shader 0
        @(negedge clock);
        a[0] = 32'h0800_0003;
        req_valid = 4'b0001;
        #1;
        check("misalign_ready", req_ready, 4'b0001);
        @(negedge clock);
        req_valid = 4'b0000;
        #1;
        check("misalign_no_write", m1_write, 1'b0);
        check("misalign_align_error", align_error, 1'b1);
        check("misalign_idle", idle, 1'b1);
        a[0] = 32'h0800_0010;

        // Reset in the middle of a stalled write
        @(negedge clock);
        req_valid      = 4'b0100;
        m1_waitrequest = 1'b1;
        #1;
        check("rstmid_accept", req_ready, 4'b0100);
        @(negedge clock);
        req_valid = 4'b1111;
        #1;
        check("rstmid_inflight", m1_write, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_write_async0", m1_write, 1'b0);
        check("rstmid_ready_forced0", req_ready, 4'b0000);
        check("rstmid_align_cleared", align_error, 1'b0);
        @(negedge clock);
        reset          = 1'b0;
        m1_waitrequest = 1'b0;
        #1;
        check("rstmid_first_grant", req_ready, 4'b0001);
        @(negedge clock);
        req_valid = 4'b0000;
        #1;
        check("rstmid_new_write", m1_write, 1'b1);
        check("rstmid_new_addr", m1_address, a[0]);
        @(negedge clock);
        #1;
        check("rstmid_back_idle", idle, 1'b1);

        // Randomized framebuffer fill against a round-robin/scoreboard model
        do_reset();
        begin
            int  next_pix [4];
            bit  presenting [4];
            int  wait_grants [4];
            int  m_last, g, done_writes, cyc, p, r, c;
            bit  m_busy, can;
            int  errs_ready, errs_wr, errs_fair, mism;
            logic [3:0] exp_ready;
            for (int k = 0; k < 4; k++) begin
                next_pix[k] = k; presenting[k] = 0; wait_grants[k] = 0;
            end
            m_last = 3; m_busy = 0; done_writes = 0; cyc = 0;
            errs_ready = 0; errs_wr = 0; errs_fair = 0;
            base_write = write_count;
            while (done_writes < NPIX && cyc < 60000) begin
                @(negedge clock);
                cyc++;
                m1_waitrequest = ($urandom_range(0, 3) == 0);
                for (int k = 0; k < 4; k++) begin
                    if (!presenting[k] && next_pix[k] < NPIX && $urandom_range(0, 3) != 0) begin
                        p = next_pix[k];
                        r = p / 160;
                        c = p % 160;
                        a[k] = 32'h0800_0000 + 32'(r << 9) + 32'(c << 1);
                        d[k] = pix_val(r, c);
                        presenting[k] = 1;
                    end
                    req_valid[k] = presenting[k];
                end
                #1;
                can = !m_busy || !m1_waitrequest;
                g = -1;
                if (can) begin
                    for (int s = 1; s <= 4; s++) begin
                        if (g < 0 && req_valid[(m_last + s) % 4]) g = (m_last + s) % 4;
                    end
                end
                exp_ready = 4'b0000;
                if (g >= 0) exp_ready[2'(g)] = 1'b1;
                if (req_ready !== exp_ready) begin
                    if (errs_ready == 0) $display("FAIL fill_ready cycle %0d: got %b expected %b", cyc, req_ready, exp_ready);
                    errs_ready++;
                end
                if (m1_write !== m_busy) errs_wr++;
                if (m1_write && !m1_waitrequest) begin
                    if (exp_q.size() == 0) errs_wr++;
                    else begin
                        if (exp_q[0] !== {m1_address, m1_writedata}) errs_wr++;
                        void'(exp_q.pop_front());
                    end
                    fb[m1_address[15:1]] = m1_writedata;
                    done_writes++;
                end
                if (g >= 0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (k != g && req_valid[k]) begin
                            wait_grants[k]++;
                            if (wait_grants[k] > 3) errs_fair++;
                        end
                    end
                    wait_grants[g] = 0;
                    exp_q.push_back({a[g], d[g]});
                    m_last = g;
                end
                m_busy = (g >= 0) ? 1'b1 : (m_busy && m1_waitrequest);
                for (int k = 0; k < 4; k++) begin
                    if (req_ready[k]) begin
                        presenting[k] = 0;
                        next_pix[k] += 4;
                    end
                end
            end
            req_valid = 4'b0000;
            check("fill_completed_writes", done_writes, NPIX);
            check("fill_ready_errors", errs_ready, 0);
            check("fill_write_errors", errs_wr, 0);
            check("fill_fairness_errors", errs_fair, 0);
            check("fill_queue_drained", exp_q.size(), 0);
            mism = 0;
            for (int rr = 0; rr < 120; rr++) begin
                for (int cc = 0; cc < 160; cc++) begin
                    if (fb[rr * 256 + cc] !== pix_val(rr, cc)) mism++;
                end
            end
            check("fill_fb_dump", mism, 0);
`ifdef PIXEL_ARB_STATS_EN
            check("fill_write_count", write_count - base_write, 32'(NPIX));
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
